// File: rtl/vram_pkg.sv
// Shared VRAM types and constants for the PPU fetch responder and its storage array.
package vram_pkg;

  localparam int unsigned VRAM_AW = 13;
  localparam int unsigned VRAM_DW = 8;

  localparam logic [VRAM_AW-1:0] MAP_BASE  = 13'h1800;
  localparam logic [VRAM_AW-1:0] MAP1_BASE = 13'h1C00;

  localparam logic [VRAM_DW-1:0] CPU_BLOCKED_DATA = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StPpuBusy,
    StCpuRd,
    StCpuWr
  } vram_state_e;

  // Both tile maps (0x1800 and 0x1C00) share addr[12:11] == 2'b11.
  function automatic logic is_map_addr(input logic [VRAM_AW-1:0] addr);
    return (addr & MAP_BASE) == MAP_BASE;
  endfunction

endpackage

// File: rtl/vram_array_1r1w.sv
// 8192x8 synchronous VRAM storage: one registered read port, one write port.
// A read and a write to the same word on the same edge return the old contents.
module vram_array_1r1w
  import vram_pkg::*;
(
  input  logic               clk,
  input  logic               re,
  input  logic [VRAM_AW-1:0] raddr,
  output logic [VRAM_DW-1:0] rdata,
  input  logic               we,
  input  logic [VRAM_AW-1:0] waddr,
  input  logic [VRAM_DW-1:0] wdata
);

  localparam int unsigned Depth = 1 << VRAM_AW;

  logic [VRAM_DW-1:0] mem [Depth];

  // No reset: contents must survive nreset_video.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/vram_fetch_responder.sv
// VRAM responder for PPU background/window fetches with CPU access arbitration.
// Optional fetch counter and trace output enabled by defining VRAM_FETCH_TRACE_EN.
module vram_fetch_responder
  import vram_pkg::*;
#(
  parameter int unsigned RD_LAT   = 2,
  parameter string       MEM_INIT = ""
) (
  input  logic               clk2,
  input  logic               nreset_video,
  input  logic [VRAM_AW-1:0] nma,
  input  logic               ppu_rd,
  output logic [VRAM_DW-1:0] ppu_data,
  output logic               ppu_vld,
  output logic               map_hit,
  input  logic               nxymu,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  input  logic [VRAM_DW-1:0] cpu_wdata,
  output logic [VRAM_DW-1:0] cpu_rdata,
  output logic               cpu_ack,
  output logic               conflict
`ifdef VRAM_FETCH_TRACE_EN
  ,
  input  logic               int_vbl,
  output logic [15:0]        ppu_fetch_cnt
`endif
);

  vram_state_e state_q, state_d;

  logic [VRAM_AW-1:0] ppu_addr, addr_q, arr_raddr;
  logic [VRAM_DW-1:0] rd_data, data_dly_q, lane_data;
  logic [RD_LAT-1:0]  vld_pipe_q, map_pipe_q;
  logic               ppu_re, cpu_re, arr_re, arr_we;
  logic               cpu_blk_q, cpu_wait, cpu_wait_q;

  assign ppu_addr = ~nma;

  // RD_LAT=1 reads straight off the bus; longer latencies read from the latched address.
  always_comb begin
    ppu_re    = (RD_LAT == 1) ? ppu_rd : vld_pipe_q[0];
    cpu_re    = (state_q == StIdle) && !ppu_rd && cpu_rd && !cpu_wr && nxymu;
    arr_re    = ppu_re || cpu_re;
    arr_raddr = cpu_re ? cpu_addr : ((RD_LAT == 1) ? ppu_addr : addr_q);
    arr_we    = (state_q == StCpuWr) && !cpu_blk_q;
    lane_data = (RD_LAT >= 3) ? data_dly_q : rd_data;
    cpu_wait  = (cpu_rd || cpu_wr) &&
                (((state_q == StIdle) && ppu_rd) || (state_q == StPpuBusy));
  end

  // CPU states are entered even while rendering so a blocked access still acks.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ppu_rd)      state_d = StPpuBusy;
        else if (cpu_wr) state_d = StCpuWr;
        else if (cpu_rd) state_d = StCpuRd;
      end
      StPpuBusy: if (!ppu_rd && !(|vld_pipe_q)) state_d = StIdle;
      StCpuRd, StCpuWr: state_d = ppu_rd ? StPpuBusy : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk2 or negedge nreset_video) begin
    if (!nreset_video) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      vld_pipe_q <= '0;
      map_pipe_q <= '0;
      data_dly_q <= '0;
      ppu_data   <= '0;
      ppu_vld    <= 1'b0;
      map_hit    <= 1'b0;
      cpu_blk_q  <= 1'b0;
      cpu_wait_q <= 1'b0;
      cpu_rdata  <= CPU_BLOCKED_DATA;
      cpu_ack    <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vld_pipe_q[0] <= ppu_rd;
      map_pipe_q[0] <= is_map_addr(ppu_addr);
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        map_pipe_q[i] <= map_pipe_q[i-1];
      end
      if (ppu_rd) addr_q <= ppu_addr;
      data_dly_q <= rd_data;
      ppu_vld    <= vld_pipe_q[RD_LAT-1];
      if (vld_pipe_q[RD_LAT-1]) begin
        ppu_data <= lane_data;
        map_hit  <= map_pipe_q[RD_LAT-1];
      end
      if (state_q == StIdle) cpu_blk_q <= !nxymu;
      if (state_q == StCpuRd) cpu_rdata <= cpu_blk_q ? CPU_BLOCKED_DATA : rd_data;
      cpu_ack    <= (state_q == StCpuRd) || (state_q == StCpuWr);
      cpu_wait_q <= cpu_wait;
      conflict   <= cpu_wait && !cpu_wait_q;
    end
  end

  vram_array_1r1w u_array (
    .clk   (clk2),
    .re    (arr_re),
    .raddr (arr_raddr),
    .rdata (rd_data),
    .we    (arr_we),
    .waddr (cpu_addr),
    .wdata (cpu_wdata)
  );

`ifdef VRAM_FETCH_TRACE_EN
  logic               vbl_q;
  logic [VRAM_AW-1:0] tr_addr_q [RD_LAT];
  logic [VRAM_AW-1:0] out_addr_q;

  always_ff @(posedge clk2 or negedge nreset_video) begin
    if (!nreset_video) begin
      vbl_q         <= 1'b0;
      ppu_fetch_cnt <= '0;
      out_addr_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) tr_addr_q[i] <= '0;
    end else begin
      vbl_q <= int_vbl;
      if (int_vbl && !vbl_q) ppu_fetch_cnt <= '0;
      else if (ppu_vld && (ppu_fetch_cnt != 16'hFFFF)) ppu_fetch_cnt <= ppu_fetch_cnt + 16'd1;
      tr_addr_q[0] <= ppu_addr;
      for (int i = 1; i < RD_LAT; i++) tr_addr_q[i] <= tr_addr_q[i-1];
      if (vld_pipe_q[RD_LAT-1]) out_addr_q <= tr_addr_q[RD_LAT-1];
    end
  end

  always_ff @(posedge clk2) begin
    if (ppu_vld) $display("vram fetch addr=%h data=%h", out_addr_q, ppu_data);
  end
`endif

endmodule

// File: tb/tb_vram_fetch_responder.sv
// Directed self-checking bench for vram_fetch_responder (RD_LAT = 2).
module tb_vram_fetch_responder;

  logic        clk2 = 1'b0;
  logic        nreset_video;
  logic [12:0] nma;
  logic        ppu_rd;
  logic [7:0]  ppu_data;
  logic        ppu_vld;
  logic        map_hit;
  logic        nxymu;
  logic [12:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        conflict;
`ifdef VRAM_FETCH_TRACE_EN
  logic        int_vbl;
  logic [15:0] ppu_fetch_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk2 = ~clk2;

  vram_fetch_responder #(.RD_LAT(2)) dut (
    .clk2         (clk2),
    .nreset_video (nreset_video),
    .nma          (nma),
    .ppu_rd       (ppu_rd),
    .ppu_data     (ppu_data),
    .ppu_vld      (ppu_vld),
    .map_hit      (map_hit),
    .nxymu        (nxymu),
    .cpu_addr     (cpu_addr),
    .cpu_rd       (cpu_rd),
    .cpu_wr       (cpu_wr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .conflict     (conflict)
`ifdef VRAM_FETCH_TRACE_EN
    ,
    .int_vbl      (int_vbl),
    .ppu_fetch_cnt(ppu_fetch_cnt)
`endif
  );

  task automatic cyc();
    @(posedge clk2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Holds the level request until cpu_ack; lat counts edges including the accepting one.
  task automatic cpu_op(input logic wr, input logic [12:0] addr, input logic [7:0] wdata,
                        output logic [7:0] rdata, output int lat);
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_wr    = wr;
    cpu_rd    = !wr;
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!cpu_ack && lat < 40);
    rdata  = cpu_rdata;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  // lat counts edges after the edge that sampled ppu_rd.
  task automatic ppu_fetch(input logic [12:0] addr, output logic [7:0] d, output logic m,
                           output int lat);
    ppu_rd = 1'b1;
    nma    = ~addr;
    cyc();
    ppu_rd = 1'b0;
    lat = 0;
    while (!ppu_vld && lat < 20) begin
      cyc();
      lat++;
    end
    d = ppu_data;
    m = map_hit;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100us");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic       m;
    int         lat;
    logic [7:0] b2b_exp [4];
    logic       seen_vld, seen_ack;

    b2b_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    nreset_video = 1'b0;
    ppu_rd = 1'b0; nma = 13'h1FFF; nxymu = 1'b1;
    cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = '0;
`ifdef VRAM_FETCH_TRACE_EN
    int_vbl = 1'b0;
`endif
    repeat (3) cyc();
    chk("rst_ppu_vld",   16'(ppu_vld),   16'h0);
    chk("rst_ppu_data",  16'(ppu_data),  16'h0);
    chk("rst_map_hit",   16'(map_hit),   16'h0);
    chk("rst_cpu_rdata", 16'(cpu_rdata), 16'h00FF);
    chk("rst_cpu_ack",   16'(cpu_ack),   16'h0);
    chk("rst_conflict",  16'(conflict),  16'h0);
    nreset_video = 1'b1;
    cyc();

    // Preload through the CPU port while not rendering.
    cpu_op(1'b1, 13'h1800, 8'h3C, rd, lat);
    chk("wr_lat", 16'(lat), 16'd2);
    cyc();
    chk("ack_pulse", 16'(cpu_ack), 16'h0);
    for (int i = 0; i < 4; i++) begin
      cpu_op(1'b1, 13'h0010 + 13'(i), b2b_exp[i], rd, lat);
      chk($sformatf("pre_wr_lat%0d", i), 16'(lat), 16'd2);
    end
    cpu_op(1'b1, 13'h1FFF, 8'h9E, rd, lat);
    cpu_op(1'b1, 13'h0000, 8'h61, rd, lat);

    // Single map fetch: nma 0x07FF is address 0x1800.
    ppu_fetch(13'h1800, rd, m, lat);
    chk("fetch_lat",  16'(lat), 16'd2);
    chk("fetch_data", 16'(rd),  16'h003C);
    chk("fetch_map",  16'(m),   16'h1);
    cyc();
    chk("vld_pulse",  16'(ppu_vld),  16'h0);
    chk("data_held",  16'(ppu_data), 16'h003C);

    // Address extremes.
    ppu_fetch(13'h1FFF, rd, m, lat);
    chk("top_data", 16'(rd), 16'h009E);
    chk("top_map",  16'(m),  16'h1);
    ppu_fetch(13'h0000, rd, m, lat);
    chk("bot_data", 16'(rd), 16'h0061);
    chk("bot_map",  16'(m),  16'h0);

    // Four back-to-back fetches return on edges 2..5.
    for (int k = 0; k < 8; k++) begin
      ppu_rd = (k < 4);
      nma    = ~(13'h0010 + 13'(k));
      cyc();
      chk($sformatf("b2b_vld%0d", k), 16'(ppu_vld), 16'((k >= 2) && (k <= 5)));
      if (k >= 2 && k <= 5) begin
        chk($sformatf("b2b_data%0d", k), 16'(ppu_data), 16'(b2b_exp[k-2]));
        chk($sformatf("b2b_map%0d", k),  16'(map_hit),  16'h0);
      end
    end

    // CPU blocked during rendering.
    cpu_op(1'b1, 13'h0100, 8'h11, rd, lat);
    nxymu = 1'b0;
    cpu_op(1'b1, 13'h0100, 8'h55, rd, lat);
    chk("blk_wr_lat", 16'(lat), 16'd2);
    cpu_op(1'b0, 13'h0100, 8'h00, rd, lat);
    chk("blk_rd_lat",  16'(lat), 16'd2);
    chk("blk_rd_data", 16'(rd),  16'h00FF);
    nxymu = 1'b1;
    cpu_op(1'b0, 13'h0100, 8'h00, rd, lat);
    chk("dropped_wr", 16'(rd), 16'h0011);
    cpu_op(1'b1, 13'h0100, 8'h55, rd, lat);
    cpu_op(1'b0, 13'h0100, 8'h00, rd, lat);
    chk("open_rd_lat",  16'(lat), 16'd2);
    chk("open_rd_data", 16'(rd),  16'h0055);

    // Same-cycle PPU and CPU request: PPU first, CPU after drain.
    ppu_rd = 1'b1; nma = ~13'h0010;
    cpu_rd = 1'b1; cpu_addr = 13'h0013;
    cyc();
    chk("conflict_on", 16'(conflict), 16'h1);
    ppu_rd = 1'b0;
    cyc();
    chk("conflict_off", 16'(conflict), 16'h0);
    cyc();
    chk("arb_ppu_vld",  16'(ppu_vld),  16'h1);
    chk("arb_ppu_data", 16'(ppu_data), 16'h00A0);
    chk("arb_no_ack",   16'(cpu_ack),  16'h0);
    lat = 0;
    while (!cpu_ack && lat < 20) begin
      cyc();
      lat++;
    end
    chk("arb_ack_wait", 16'(lat),       16'd3);
    chk("arb_cpu_data", 16'(cpu_rdata), 16'h00A3);
    cpu_rd = 1'b0;
    cyc();
    chk("arb_ack_pulse", 16'(cpu_ack), 16'h0);

    // Reset one cycle after a fetch request.
    ppu_rd = 1'b1; nma = ~13'h1800;
    cyc();
    ppu_rd = 1'b0;
    cyc();
    nreset_video = 1'b0;
    #1;
    chk("mid_rst_data",  16'(ppu_data),  16'h0);
    chk("mid_rst_rdata", 16'(cpu_rdata), 16'h00FF);
    chk("mid_rst_vld",   16'(ppu_vld),   16'h0);
    cyc();
    cyc();
    nreset_video = 1'b1;
    seen_vld = 1'b0;
    seen_ack = 1'b0;
    repeat (6) begin
      cyc();
      if (ppu_vld) seen_vld = 1'b1;
      if (cpu_ack) seen_ack = 1'b1;
    end
    chk("post_rst_vld", 16'(seen_vld), 16'h0);
    chk("post_rst_ack", 16'(seen_ack), 16'h0);

`ifdef VRAM_FETCH_TRACE_EN
    int_vbl = 1'b1;
    cyc();
    int_vbl = 1'b0;
    for (int i = 0; i < 3; i++) ppu_fetch(13'h0010, rd, m, lat);
    cyc();
    chk("cnt_three", ppu_fetch_cnt, 16'd3);
    int_vbl = 1'b1;
    cyc();
    chk("cnt_clear", ppu_fetch_cnt, 16'd0);
    int_vbl = 1'b0;
    for (int i = 0; i < 2; i++) ppu_fetch(13'h0011, rd, m, lat);
    cyc();
    chk("cnt_two", ppu_fetch_cnt, 16'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
